// File: rtl/interval_sequencer.sv
// ---------------------------------------------------------------------------
// interval_sequencer
//
// Sequences a small programmable table of countdown intervals through an
// external countdown datapath. Each table entry holds a seconds digit and a
// minutes digit. For each entry, the sequencer does three things in order:
// it loads the seconds digit, then loads the minutes digit, then lets the
// countdown run until it reports expiry. After the last entry, it either
// loops back to the first entry (repeat_en high) or parks in DONE and
// blinks done_led.
//
// Ports
//   CLOCK_50     in   single clock, rising edge
//   reset        in   synchronous, active-high; clears FSM, counters and table
//   wr_en        in   table write strobe (honoured only in IDLE or DONE)
//   wr_addr[1:0] in   table entry to write
//   wr_sec[3:0]  in   seconds digit to store
//   wr_min[3:0]  in   minutes digit to store
//   start        in   pulse: begin a program (ignored when prog_len == 0)
//   pause        in   pulse: toggle between RUN and PAUSE
//   abort        in   pulse: return to IDLE from any state
//   repeat_en    in   level: loop the program instead of finishing
//                     (the name avoids the reserved word "repeat")
//   prog_len[2:0] in  number of entries to run, clamped to NUM_INT
//   cd_timesup   in   countdown expiry level (only observed in RUN)
//   cd_set_sec   out  one-cycle load strobe for the seconds digit
//   cd_set_min   out  one-cycle load strobe for the minutes digit
//   cd_run       out  countdown enable
//   cd_sec_val[3:0] out  seconds digit of the current entry
//   cd_min_val[3:0] out  minutes digit of the current entry
//   cur_idx[1:0] out  index of the current table entry
//   busy         out  high while a program is in progress
//   done_led     out  blinks while in DONE
//   state[2:0]   out  raw state register
// ---------------------------------------------------------------------------
module interval_sequencer #(
  parameter int NUM_INT      = 4,
  parameter int BLINK_CYCLES = 25000000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [3:0] wr_sec,
  input  logic [3:0] wr_min,
  input  logic       start,
  input  logic       pause,
  input  logic       abort,
  input  logic       repeat_en,
  input  logic [2:0] prog_len,
  output logic       cd_set_sec,
  output logic       cd_set_min,
  output logic       cd_run,
  output logic [3:0] cd_sec_val,
  output logic [3:0] cd_min_val,
  input  logic       cd_timesup,
  output logic [1:0] cur_idx,
  output logic       busy,
  output logic       done_led,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_LDSEC = 3'b001,
    S_LDMIN = 3'b010,
    S_RUN   = 3'b011,
    S_PAUSE = 3'b100,
    S_NEXT  = 3'b101,
    S_DONE  = 3'b110
  } state_e;

  localparam logic [2:0] NUM_INT_L = 3'(NUM_INT);

  // The blink counter only needs to hold BLINK_CYCLES-1, so size it for that.
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BW-1:0] BLINK_RELOAD = BW'(BLINK_CYCLES - 1);

  state_e        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [2:0]    len_q, len_d;
  logic [BW-1:0] blink_cnt_q;
  logic          led_q;
  logic          set_sec_q, set_min_q, run_q, busy_q;
  logic [7:0]    tbl_q [NUM_INT];

  logic          start_ok;
  logic [2:0]    len_clamped;
  logic          more_entries;
  logic          wr_allowed;

  assign start_ok     = start && (prog_len != 3'd0);
  assign len_clamped  = (prog_len > NUM_INT_L) ? NUM_INT_L : prog_len;
  assign more_entries = (({1'b0, idx_q} + 3'd1) < len_q);
  assign wr_allowed   = wr_en && ((state_q == S_IDLE) || (state_q == S_DONE))
                        && (int'(wr_addr) < NUM_INT);

  // Next-state logic. Priority: abort, then the per-state rules, where
  // cd_timesup is tested before pause inside RUN.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    if (abort) begin
      state_d = S_IDLE;
      idx_d   = 2'd0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            state_d = S_LDSEC;
            idx_d   = 2'd0;
            len_d   = len_clamped;
          end
        end
        S_LDSEC: state_d = S_LDMIN;
        S_LDMIN: state_d = S_RUN;
        S_RUN: begin
          if (cd_timesup) begin
            state_d = S_NEXT;
          end else if (pause) begin
            state_d = S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (pause) begin
            state_d = S_RUN;
          end
        end
        S_NEXT: begin
          if (more_entries) begin
            idx_d   = idx_q + 2'd1;
            state_d = S_LDSEC;
          end else if (repeat_en) begin
            idx_d   = 2'd0;
            state_d = S_LDSEC;
          end else begin
            state_d = S_DONE;
          end
        end
        default: begin
          state_d = S_IDLE;
          idx_d   = 2'd0;
        end
      endcase
    end
  end

  // State register, registered outputs, blink timer and interval table.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= 2'd0;
      len_q       <= 3'd0;
      blink_cnt_q <= '0;
      led_q       <= 1'b0;
      set_sec_q   <= 1'b0;
      set_min_q   <= 1'b0;
      run_q       <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i < NUM_INT; i++) begin
        tbl_q[i] <= 8'd0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      // Outputs are decoded from the next state so they line up with state_q.
      set_sec_q <= (state_d == S_LDSEC);
      set_min_q <= (state_d == S_LDMIN);
      run_q     <= (state_d == S_RUN);
      busy_q    <= (state_d == S_LDSEC) || (state_d == S_LDMIN) ||
                   (state_d == S_RUN)   || (state_d == S_PAUSE) ||
                   (state_d == S_NEXT);

      // The LED is dark on the DONE entry cycle. On the cycle after entry it
      // lights, because the counter starts at zero. After that it flips every
      // BLINK_CYCLES cycles.
      if (state_d == S_DONE) begin
        if (state_q != S_DONE) begin
          blink_cnt_q <= '0;
          led_q       <= 1'b0;
        end else if (blink_cnt_q == '0) begin
          blink_cnt_q <= BLINK_RELOAD;
          led_q       <= ~led_q;
        end else begin
          blink_cnt_q <= blink_cnt_q - 1'b1;
        end
      end else begin
        blink_cnt_q <= '0;
        led_q       <= 1'b0;
      end

      // A write that coincides with start in IDLE lands before LDSEC reads.
      if (wr_allowed) begin
        tbl_q[wr_addr] <= {wr_min, wr_sec};
      end
    end
  end

  assign cd_set_sec = set_sec_q;
  assign cd_set_min = set_min_q;
  assign cd_run     = run_q;
  assign busy       = busy_q;
  assign done_led   = led_q;
  assign cur_idx    = idx_q;
  assign state      = state_q;
  assign cd_sec_val = tbl_q[idx_q][3:0];
  assign cd_min_val = tbl_q[idx_q][7:4];

endmodule

// File: tb/tb_interval_sequencer.sv
module tb_interval_sequencer;
  localparam int B = 4;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b0, wr_en = 1'b0, start = 1'b0, pause = 1'b0;
  logic       abort = 1'b0, repeat_en = 1'b0, cd_timesup = 1'b0;
  logic [1:0] wr_addr = 2'd0;
  logic [3:0] wr_sec = 4'd0, wr_min = 4'd0;
  logic [2:0] prog_len = 3'd0;
  logic       cd_set_sec, cd_set_min, cd_run, busy, done_led;
  logic [3:0] cd_sec_val, cd_min_val;
  logic [1:0] cur_idx;
  logic [2:0] state;

  int checks = 0;
  int failures = 0;
  // Reference copy of the interval table: {min, sec} per entry.
  logic [7:0] mtbl [4];

  interval_sequencer #(.NUM_INT(4), .BLINK_CYCLES(B)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_sec(wr_sec), .wr_min(wr_min), .start(start), .pause(pause),
    .abort(abort), .repeat_en(repeat_en), .prog_len(prog_len),
    .cd_set_sec(cd_set_sec), .cd_set_min(cd_set_min), .cd_run(cd_run),
    .cd_sec_val(cd_sec_val), .cd_min_val(cd_min_val), .cd_timesup(cd_timesup),
    .cur_idx(cur_idx), .busy(busy), .done_led(done_led), .state(state)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic write_entry(input logic [1:0] a, input logic [3:0] mn, input logic [3:0] sc);
    wr_en = 1'b1; wr_addr = a; wr_min = mn; wr_sec = sc;
    tick();
    wr_en = 1'b0;
    mtbl[a] = {mn, sc};
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) mtbl[i] = 8'd0;
  endtask

  task automatic pulse_start(input logic [2:0] pl);
    prog_len = pl; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_timesup;
    cd_timesup = 1'b1;
    tick();
    cd_timesup = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if ({state, cd_set_sec, cd_set_min, cd_run, busy, done_led, cur_idx, cd_sec_val, cd_min_val} !== 18'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h want 0",
               {state, cd_set_sec, cd_set_min, cd_run, busy, done_led, cur_idx, cd_sec_val, cd_min_val});
    end
  endtask

  task automatic test_basic;
    write_entry(2'd0, 4'd2, 4'd5);
    write_entry(2'd1, 4'd0, 4'd3);
    pulse_start(3'd2);
    checks++;
    if ({state, cd_set_sec, cd_set_min, cd_run, cd_sec_val} !== {3'd1, 3'b100, 4'd5}) begin
      failures++;
      $display("FAIL basic_ldsec: got %b want %b", {state, cd_set_sec, cd_set_min, cd_run, cd_sec_val}, {3'd1, 3'b100, 4'd5});
    end
    tick();
    checks++;
    if ({state, cd_set_sec, cd_set_min, cd_run, cd_min_val} !== {3'd2, 3'b010, 4'd2}) begin
      failures++;
      $display("FAIL basic_ldmin: got %b want %b", {state, cd_set_sec, cd_set_min, cd_run, cd_min_val}, {3'd2, 3'b010, 4'd2});
    end
    tick();
    checks++;
    if ({state, cd_set_sec, cd_set_min, cd_run, busy} !== {3'd3, 3'b001, 1'b1}) begin
      failures++;
      $display("FAIL basic_run: got %b want %b", {state, cd_set_sec, cd_set_min, cd_run, busy}, {3'd3, 3'b001, 1'b1});
    end
    tick(); tick();
    checks++;
    if ({state, cd_run} !== {3'd3, 1'b1}) begin
      failures++;
      $display("FAIL basic_run_hold: got %b want %b", {state, cd_run}, {3'd3, 1'b1});
    end
    pulse_timesup();
    checks++;
    if ({state, busy, cd_run} !== {3'd5, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL basic_next: got %b want %b", {state, busy, cd_run}, {3'd5, 1'b1, 1'b0});
    end
    tick();
    checks++;
    if ({state, cd_set_sec, cur_idx, cd_sec_val} !== {3'd1, 1'b1, 2'd1, 4'd3}) begin
      failures++;
      $display("FAIL basic_second_ldsec: got %b want %b", {state, cd_set_sec, cur_idx, cd_sec_val}, {3'd1, 1'b1, 2'd1, 4'd3});
    end
  endtask

  task automatic test_done_blink;
    logic exp;
    tick(); tick();
    pulse_timesup();
    tick();
    checks++;
    if ({state, busy, done_led} !== {3'd6, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL done_entry: got %b want %b", {state, busy, done_led}, {3'd6, 1'b0, 1'b0});
    end
    // k cycles after the DONE entry: lit for B cycles, dark for B cycles.
    for (int k = 1; k <= 3 * B; k++) begin
      tick();
      exp = (((k - 1) / B) % 2) == 0;
      checks++;
      if (done_led !== exp) begin
        failures++;
        $display("FAIL done_blink k=%0d: got %b want %b", k, done_led, exp);
      end
    end
  endtask

  task automatic test_pause;
    pulse_start(3'd1);
    tick(); tick();
    checks++;
    if (state !== 3'd3) begin
      failures++;
      $display("FAIL pause_setup: got %0d want 3", state);
    end
    pause = 1'b1; tick(); pause = 1'b0;
    checks++;
    if ({state, cd_run} !== {3'd4, 1'b0}) begin
      failures++;
      $display("FAIL pause_enter: got %b want %b", {state, cd_run}, {3'd4, 1'b0});
    end
    cd_timesup = 1'b1; tick(); tick(); cd_timesup = 1'b0;
    checks++;
    if (state !== 3'd4) begin
      failures++;
      $display("FAIL pause_ignores_timesup: got %0d want 4", state);
    end
    pause = 1'b1; tick(); pause = 1'b0;
    checks++;
    if ({state, cd_run} !== {3'd3, 1'b1}) begin
      failures++;
      $display("FAIL pause_resume: got %b want %b", {state, cd_run}, {3'd3, 1'b1});
    end
    pause = 1'b1; cd_timesup = 1'b1; tick(); pause = 1'b0; cd_timesup = 1'b0;
    checks++;
    if (state !== 3'd5) begin
      failures++;
      $display("FAIL pause_vs_timesup: got %0d want 5", state);
    end
    tick();
    checks++;
    if (state !== 3'd6) begin
      failures++;
      $display("FAIL pause_len1_done: got %0d want 6", state);
    end
  endtask

  task automatic test_repeat;
    repeat_en = 1'b1;
    pulse_start(3'd2);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if ({state, cd_set_sec, cur_idx, cd_sec_val} !== {3'd1, 1'b1, 2'(i), mtbl[i][3:0]}) begin
          failures++;
          $display("FAIL repeat_ldsec r=%0d i=%0d: got %b want %b", r, i,
                   {state, cd_set_sec, cur_idx, cd_sec_val}, {3'd1, 1'b1, 2'(i), mtbl[i][3:0]});
        end
        tick(); tick();
        pulse_timesup();
        tick();
      end
    end
    repeat_en = 1'b0;
    abort = 1'b1; tick(); abort = 1'b0;
    checks++;
    if ({state, cd_set_sec, cd_set_min, cd_run, busy} !== 7'd0) begin
      failures++;
      $display("FAIL repeat_abort: got %b want 0", {state, cd_set_sec, cd_set_min, cd_run, busy});
    end
  endtask

  task automatic test_write_start;
    wr_en = 1'b1; wr_addr = 2'd0; wr_min = 4'd4; wr_sec = 4'd6;
    prog_len = 3'd1; start = 1'b1;
    tick();
    wr_en = 1'b0; start = 1'b0;
    mtbl[0] = 8'h46;
    checks++;
    if ({state, cd_sec_val} !== {3'd1, 4'd6}) begin
      failures++;
      $display("FAIL write_with_start_sec: got %b want %b", {state, cd_sec_val}, {3'd1, 4'd6});
    end
    tick();
    checks++;
    if (cd_min_val !== 4'd4) begin
      failures++;
      $display("FAIL write_with_start_min: got %0d want 4", cd_min_val);
    end
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_len_limits;
    pulse_start(3'd0);
    checks++;
    if ({state, busy} !== 4'd0) begin
      failures++;
      $display("FAIL len0_ignored: got %b want 0", {state, busy});
    end
    write_entry(2'd2, 4'd7, 4'd9);
    write_entry(2'd3, 4'd1, 4'd1);
    pulse_start(3'd7);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({state, cur_idx, cd_sec_val} !== {3'd1, 2'(i), mtbl[i][3:0]}) begin
        failures++;
        $display("FAIL len7_entry i=%0d: got %b want %b", i, {state, cur_idx, cd_sec_val}, {3'd1, 2'(i), mtbl[i][3:0]});
      end
      tick(); tick();
      if (i == 0) begin
        // Write while running; the model table is deliberately not updated.
        wr_en = 1'b1; wr_addr = 2'd0; wr_min = 4'd15; wr_sec = 4'd15;
        tick();
        wr_en = 1'b0;
      end
      pulse_timesup();
      tick();
    end
    checks++;
    if ({state, busy} !== {3'd6, 1'b0}) begin
      failures++;
      $display("FAIL len7_done: got %b want %b", {state, busy}, {3'd6, 1'b0});
    end
    pulse_start(3'd1);
    checks++;
    if ({state, cur_idx, cd_sec_val} !== {3'd1, 2'd0, mtbl[0][3:0]}) begin
      failures++;
      $display("FAIL wr_in_run_ignored_sec: got %b want %b", {state, cur_idx, cd_sec_val}, {3'd1, 2'd0, mtbl[0][3:0]});
    end
    tick();
    checks++;
    if (cd_min_val !== mtbl[0][7:4]) begin
      failures++;
      $display("FAIL wr_in_run_ignored_min: got %0d want %0d", cd_min_val, mtbl[0][7:4]);
    end
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_abort;
    pulse_start(3'd2);
    tick(); tick();
    abort = 1'b1; cd_timesup = 1'b1; pause = 1'b1;
    tick();
    abort = 1'b0; cd_timesup = 1'b0; pause = 1'b0;
    checks++;
    if ({state, cd_run, cd_set_sec, cd_set_min, busy, done_led} !== 8'd0) begin
      failures++;
      $display("FAIL abort_in_run: got %b want 0", {state, cd_run, cd_set_sec, cd_set_min, busy, done_led});
    end
    checks++;
    if ({cd_min_val, cd_sec_val} !== mtbl[0]) begin
      failures++;
      $display("FAIL abort_table_kept: got %h want %h", {cd_min_val, cd_sec_val}, mtbl[0]);
    end
  endtask

  task automatic test_reset_in_done;
    pulse_start(3'd1);
    tick(); tick();
    pulse_timesup();
    tick(); tick(); tick();
    checks++;
    if ({state, done_led} !== {3'd6, 1'b1}) begin
      failures++;
      $display("FAIL pre_reset_done: got %b want %b", {state, done_led}, {3'd6, 1'b1});
    end
    reset = 1'b1; abort = 1'b1; start = 1'b1; prog_len = 3'd1;
    wr_en = 1'b1; wr_addr = 2'd1; wr_min = 4'd9; wr_sec = 4'd9;
    tick();
    reset = 1'b0; abort = 1'b0; start = 1'b0; wr_en = 1'b0;
    for (int i = 0; i < 4; i++) mtbl[i] = 8'd0;
    checks++;
    if ({state, cd_set_sec, cd_set_min, cd_run, busy, done_led, cur_idx, cd_sec_val, cd_min_val} !== 18'd0) begin
      failures++;
      $display("FAIL reset_in_done: got %h want 0",
               {state, cd_set_sec, cd_set_min, cd_run, busy, done_led, cur_idx, cd_sec_val, cd_min_val});
    end
    pulse_start(3'd4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({state, cur_idx, cd_min_val, cd_sec_val} !== {3'd1, 2'(i), 8'd0}) begin
        failures++;
        $display("FAIL table_cleared i=%0d: got %b want %b", i, {state, cur_idx, cd_min_val, cd_sec_val}, {3'd1, 2'(i), 8'd0});
      end
      tick(); tick();
      pulse_timesup();
      tick();
    end
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_random;
    logic [2:0] pl;
    int len;
    int waitn;
    for (int it = 0; it < 8; it++) begin
      for (int a = 0; a < 4; a++) write_entry(2'(a), 4'($urandom), 4'($urandom));
      pl  = 3'($urandom_range(1, 7));
      len = (pl > 3'd4) ? 4 : int'(pl);
      pulse_start(pl);
      for (int i = 0; i < len; i++) begin
        checks++;
        if ({state, cd_set_sec, cur_idx, cd_sec_val} !== {3'd1, 1'b1, 2'(i), mtbl[i][3:0]}) begin
          failures++;
          $display("FAIL rand_ldsec it=%0d i=%0d: got %b want %b", it, i,
                   {state, cd_set_sec, cur_idx, cd_sec_val}, {3'd1, 1'b1, 2'(i), mtbl[i][3:0]});
        end
        tick();
        checks++;
        if ({state, cd_set_min, cd_min_val} !== {3'd2, 1'b1, mtbl[i][7:4]}) begin
          failures++;
          $display("FAIL rand_ldmin it=%0d i=%0d: got %b want %b", it, i,
                   {state, cd_set_min, cd_min_val}, {3'd2, 1'b1, mtbl[i][7:4]});
        end
        tick();
        waitn = $urandom_range(0, 3);
        for (int w = 0; w < waitn; w++) tick();
        checks++;
        if ({state, cd_run} !== {3'd3, 1'b1}) begin
          failures++;
          $display("FAIL rand_run it=%0d i=%0d: got %b want %b", it, i, {state, cd_run}, {3'd3, 1'b1});
        end
        if ($urandom_range(0, 1) == 1) begin
          pause = 1'b1; tick(); pause = 1'b0;
          tick();
          checks++;
          if ({state, cd_run} !== {3'd4, 1'b0}) begin
            failures++;
            $display("FAIL rand_pause it=%0d i=%0d: got %b want %b", it, i, {state, cd_run}, {3'd4, 1'b0});
          end
          pause = 1'b1; tick(); pause = 1'b0;
        end
        pulse_timesup();
        checks++;
        if (state !== 3'd5) begin
          failures++;
          $display("FAIL rand_next it=%0d i=%0d: got %0d want 5", it, i, state);
        end
        tick();
      end
      checks++;
      if ({state, busy, done_led} !== {3'd6, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL rand_done it=%0d: got %b want %b", it, {state, busy, done_led}, {3'd6, 1'b0, 1'b0});
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mtbl[i] = 8'd0;
    tick();
    test_reset();
    test_basic();
    test_done_blink();
    test_pause();
    test_repeat();
    test_write_start();
    test_len_limits();
    test_abort();
    test_reset_in_done();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/interval_sequencer.md
INTERVAL_SEQUENCER -- requirements
Module: interval_sequencer

Interface
REQ-001 SHALL have parameter NUM_INT, default 4, meaning number of interval table entries (2-bit index).
REQ-002 SHALL have parameter BLINK_CYCLES, default 25000000, meaning CLOCK_50 cycles per done_led half-period.
REQ-003 SHALL have port CLOCK_50 input 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset input 1, synchronous active-high reset.
REQ-005 SHALL have ports wr_en input 1, wr_addr input 2, wr_sec input 4, wr_min input 4, a table write of one interval (units seconds, units minutes).
REQ-006 SHALL have ports start input 1, pause input 1, abort input 1, all single-cycle pulses; and repeat input 1, a level.
REQ-007 SHALL have port prog_len input 3, number of entries to run, sampled on accepted start.
REQ-008 SHALL have ports cd_set_sec output 1, cd_set_min output 1, cd_run output 1, cd_sec_val output 4, cd_min_val output 4, driving the countdown datapath load/run controls.
REQ-009 SHALL have port cd_timesup input 1, the countdown expiry level.
REQ-010 SHALL have ports cur_idx output 2, busy output 1, done_led output 1, state output 3.

Function
REQ-011 SHALL implement states IDLE=000, LDSEC=001, LDMIN=010, RUN=011, PAUSE=100, NEXT=101, DONE=110.
REQ-012 SHALL write table[wr_addr] <= {wr_min, wr_sec} on wr_en only in IDLE or DONE; writes in other states are ignored.
REQ-013 SHALL, in IDLE on start with prog_len!=0, latch len = min(prog_len, NUM_INT), clear cur_idx, go to LDSEC; start with prog_len==0 is ignored.
REQ-014 SHALL hold cd_set_sec=1 for exactly one cycle in LDSEC, cd_sec_val=table[cur_idx].sec, then go to LDMIN.
REQ-015 SHALL hold cd_set_min=1 for exactly one cycle in LDMIN, cd_min_val=table[cur_idx].min, then go to RUN.
REQ-016 SHALL assert cd_run=1 only in RUN; cd_set_sec, cd_set_min, cd_run are mutually exclusive.
REQ-017 SHALL in RUN go to NEXT on cd_timesup=1; else toggle to PAUSE on pause; in PAUSE return to RUN on pause.
REQ-018 SHALL ignore cd_timesup in all states other than RUN.
REQ-019 SHALL in NEXT (one cycle): if cur_idx+1 < len, increment cur_idx and go to LDSEC; else if repeat=1, clear cur_idx and go to LDSEC; else go to DONE.
REQ-020 SHALL in DONE toggle done_led every BLINK_CYCLES cycles, first assertion on the DONE entry cycle+1; done_led=0 in all other states.
REQ-021 SHALL leave DONE to LDSEC (cur_idx=0, len re-latched) on start with prog_len!=0.
REQ-022 SHALL on abort in any state go to IDLE next cycle, deasserting cd_run, cd_set_*, done_led; table contents retained.
REQ-023 SHALL assert busy in LDSEC, LDMIN, RUN, PAUSE, NEXT; state output mirrors the state register.
REQ-024 SHALL resolve simultaneous events by priority: abort > cd_timesup > start > pause; wr_en coincident with start in IDLE writes before the first LDSEC read.
REQ-025 SHALL drive cd_sec_val/cd_min_val from table[cur_idx] combinationally in all states.

Reset
REQ-026 SHALL on reset go to IDLE, cur_idx=0, len=0, blink counter=0, all outputs 0, table entries cleared to 0, regardless of state.
REQ-027 SHALL give reset priority over every other input including abort and wr_en.

Verification
REQ-028 Write table[0]={2,5},[1]={0,3}; prog_len=2, start -> cd_set_sec with val 5 one cycle, cd_set_min val 2 next cycle, cd_run next; cd_timesup -> NEXT, LDSEC with val 3.
REQ-029 After entry 1 expires with repeat=0 -> DONE, busy=0, done_led toggles every BLINK_CYCLES (use BLINK_CYCLES=4 in bench).
REQ-030 repeat=1, prog_len=2 -> after entry 1 expiry cur_idx=0, cd_set_sec val 5, sequence continues indefinitely.
REQ-031 In RUN pulse pause -> cd_run=0, state=100; pulse pause again -> cd_run=1; pause with cd_timesup same cycle -> NEXT.
REQ-032 prog_len=7 -> runs 4 entries; prog_len=0 start -> stays IDLE; wr_en in RUN -> table unchanged.
REQ-033 abort mid-RUN -> IDLE next cycle, cd_run=0; reset in DONE -> all outputs 0, table reads 0.
